wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_pkg.sv | 13 +
 rtl/wb_cmd_master_if.sv | 37 +++
 rtl/wb_timeout_ctr.sv | 32 +++
 rtl/wb_cmd_master.sv | 121 ++++++++++++
 tb/tb_wb_cmd_master.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_cmd_pkg.sv
// Shared types and widths for the command-to-Wishbone master.
// Imported by the interface, the top and the timeout counter.
package wb_cmd_pkg;
   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;
endpackage

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone master signal bundle.
// The master modport is the wb_cmd_master side; the slave modport is its environment.
interface wb_cmd_master_if;
   import wb_cmd_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   logic                cmd_we;
   logic [WB_ADR_W-1:0] cmd_adr;
   logic [WB_DAT_W-1:0] cmd_dat;
   logic [WB_SEL_W-1:0] cmd_sel;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [WB_DAT_W-1:0] rsp_dat;
   logic                rsp_err;
   logic                wbm_cyc_o;
   logic                wbm_stb_o;
   logic                wbm_we_o;
   logic [WB_ADR_W-1:0] wbm_adr_o;
   logic [WB_DAT_W-1:0] wbm_dat_o;
   logic [WB_SEL_W-1:0] wbm_sel_o;
   logic [WB_DAT_W-1:0] wbm_dat_i;
   logic                wbm_ack_i;
   logic                busy;

   modport master (
      input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
      output cmd_ready, rsp_valid, rsp_dat, rsp_err,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, busy
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
      input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, busy
   );
endinterface

// File: rtl/wb_timeout_ctr.sv
// 16-bit bus-cycle timeout counter; tc flags the last allowed cycle (count == LIMIT-1).
module wb_timeout_ctr #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic srst,
   input  logic clear,
   input  logic enable,
   output logic tc
);
   logic [15:0] cnt_reg;
   logic [15:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (clear) begin
         cnt_next = '0;
      end else if (enable) begin
         cnt_next = cnt_reg + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign tc = (cnt_reg == 16'(LIMIT - 1));
endmodule

// File: rtl/wb_cmd_master.sv
// Turns one valid/ready command into a single Wishbone classic cycle and returns
// a response; cycles without ack within TIMEOUT_CYCLES end with rsp_err=1.
module wb_cmd_master
   import wb_cmd_pkg::*;
#(
   parameter int                  TIMEOUT_CYCLES = 255,
   parameter logic [WB_DAT_W-1:0] RSP_ERR_DATA   = 32'h0000_0000
) (
   input logic            wb_clk_i,
   input logic            wb_rst_i,
   wb_cmd_master_if.master bus
);
   state_t              state_reg, state_next;
   logic                cyc_reg, cyc_next;
   logic                we_reg, we_next;
   logic [WB_ADR_W-1:0] adr_reg, adr_next;
   logic [WB_DAT_W-1:0] dat_reg, dat_next;
   logic [WB_SEL_W-1:0] sel_reg, sel_next;
   logic [WB_DAT_W-1:0] rsp_dat_reg, rsp_dat_next;
   logic                rsp_err_reg, rsp_err_next;
   logic                ctr_clear;
   logic                ctr_enable;
   logic                ctr_tc;

   wb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk    (wb_clk_i),
      .srst   (wb_rst_i),
      .clear  (ctr_clear),
      .enable (ctr_enable),
      .tc     (ctr_tc)
   );

   always_comb begin
      state_next   = state_reg;
      cyc_next     = cyc_reg;
      we_next      = we_reg;
      adr_next     = adr_reg;
      dat_next     = dat_reg;
      sel_next     = sel_reg;
      rsp_dat_next = rsp_dat_reg;
      rsp_err_next = rsp_err_reg;
      ctr_clear    = 1'b0;
      ctr_enable   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               state_next = ST_BUS;
               cyc_next   = 1'b1;
               we_next    = bus.cmd_we;
               adr_next   = bus.cmd_adr;
               dat_next   = bus.cmd_dat;
               sel_next   = bus.cmd_sel;
               ctr_clear  = 1'b1;
            end
         end
         ST_BUS: begin
            // Ack is checked before the terminal count so a last-cycle ack wins.
            if (bus.wbm_ack_i || ctr_tc) begin
               state_next   = ST_RESP;
               cyc_next     = 1'b0;
               we_next      = 1'b0;
               adr_next     = '0;
               dat_next     = '0;
               sel_next     = '0;
               rsp_err_next = ~bus.wbm_ack_i;
               if (bus.wbm_ack_i) begin
                  rsp_dat_next = we_reg ? '0 : bus.wbm_dat_i;
               end else begin
                  rsp_dat_next = RSP_ERR_DATA;
               end
            end else begin
               ctr_enable = 1'b1;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_next   = ST_IDLE;
               rsp_dat_next = '0;
               rsp_err_next = 1'b0;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_reg   <= ST_IDLE;
         cyc_reg     <= 1'b0;
         we_reg      <= 1'b0;
         adr_reg     <= '0;
         dat_reg     <= '0;
         sel_reg     <= '0;
         rsp_dat_reg <= '0;
         rsp_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cyc_reg     <= cyc_next;
         we_reg      <= we_next;
         adr_reg     <= adr_next;
         dat_reg     <= dat_next;
         sel_reg     <= sel_next;
         rsp_dat_reg <= rsp_dat_next;
         rsp_err_reg <= rsp_err_next;
      end
   end

   assign bus.cmd_ready = (state_reg == ST_IDLE);
   assign bus.busy      = (state_reg != ST_IDLE);
   assign bus.rsp_valid = (state_reg == ST_RESP);
   assign bus.rsp_dat   = rsp_dat_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign bus.wbm_cyc_o = cyc_reg;
   assign bus.wbm_stb_o = cyc_reg;
   assign bus.wbm_we_o  = we_reg;
   assign bus.wbm_adr_o = adr_reg;
   assign bus.wbm_dat_o = dat_reg;
   assign bus.wbm_sel_o = sel_reg;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master with an 8-cycle timeout: directed table,
// reset-abort sequence and randomized commands against a response model.
module tb_wb_cmd_master;
   localparam int          TO      = 8;
   localparam logic [31:0] ERR_DAT = 32'hDEAD_BEEF;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          ack_delay;   // ack driven in BUS cycle index ack_delay (0-based)
      logic [31:0] sdata;
      int          rsp_wait;    // cycles rsp_ready is held low
      logic [31:0] exp_dat;
      logic        exp_err;
      int          exp_len;     // cycles with cyc high
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   wb_cmd_master_if ifc ();

   wb_cmd_master #(
      .TIMEOUT_CYCLES (TO),
      .RSP_ERR_DATA   (ERR_DAT)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (ifc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent response model: ack inside the first TO bus cycles wins, else timeout.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (v.ack_delay < TO) begin
         r.exp_dat = v.we ? 32'h0 : v.sdata;
         r.exp_err = 1'b0;
         r.exp_len = v.ack_delay + 1;
      end else begin
         r.exp_dat = ERR_DAT;
         r.exp_err = 1'b1;
         r.exp_len = TO;
      end
      return r;
   endfunction

   task automatic run_cmd(input vec_t v, output logic [31:0] g_dat, output logic g_err,
                          output int len);
      int n = 0;
      logic [31:0] d0;
      logic        e0;
      chk("idle_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
      chk("idle_busy", 32'(ifc.busy), 32'd0);
      ifc.cmd_valid = 1'b1;
      ifc.cmd_we    = v.we;
      ifc.cmd_adr   = v.adr;
      ifc.cmd_dat   = v.dat;
      ifc.cmd_sel   = v.sel;
      tick();
      ifc.cmd_valid = 1'b0;
      ifc.cmd_adr   = $urandom;
      ifc.cmd_dat   = $urandom;
      while (ifc.wbm_cyc_o === 1'b1 && n < 40) begin
         chk("bus_stb", 32'(ifc.wbm_stb_o), 32'd1);
         chk("bus_we", 32'(ifc.wbm_we_o), 32'(v.we));
         chk("bus_adr", ifc.wbm_adr_o, v.adr);
         chk("bus_dat", ifc.wbm_dat_o, v.dat);
         chk("bus_sel", 32'(ifc.wbm_sel_o), 32'(v.sel));
         chk("bus_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
         chk("bus_busy", 32'(ifc.busy), 32'd1);
         chk("bus_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
         ifc.wbm_ack_i = (n == v.ack_delay);
         ifc.wbm_dat_i = v.sdata;
         tick();
         ifc.wbm_ack_i = 1'b0;
         n++;
      end
      len = n;
      chk("rsp_valid_after_bus", 32'(ifc.rsp_valid), 32'd1);
      chk("idle_bus_stb", 32'(ifc.wbm_stb_o), 32'd0);
      chk("idle_bus_we", 32'(ifc.wbm_we_o), 32'd0);
      chk("idle_bus_dat", ifc.wbm_dat_o, 32'd0);
      d0 = ifc.rsp_dat;
      e0 = ifc.rsp_err;
      // Hold off rsp_ready while offering another command and stray acks.
      for (int w = 0; w < v.rsp_wait; w++) begin
         ifc.cmd_valid = 1'b1;
         ifc.wbm_ack_i = 1'($urandom_range(0, 1));
         tick();
         chk("hold_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
         chk("hold_rsp_dat", ifc.rsp_dat, d0);
         chk("hold_rsp_err", 32'(ifc.rsp_err), 32'(e0));
         chk("hold_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
         chk("hold_no_accept", 32'(ifc.wbm_cyc_o), 32'd0);
      end
      ifc.cmd_valid = 1'b0;
      ifc.wbm_ack_i = 1'b0;
      ifc.rsp_ready = 1'b1;
      tick();
      ifc.rsp_ready = 1'b0;
      chk("post_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      chk("post_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
      chk("post_busy", 32'(ifc.busy), 32'd0);
      g_dat = d0;
      g_err = e0;
   endtask

   vec_t vecs[6];

   initial begin
      logic [31:0] g_dat;
      logic        g_err;
      int          len;
      vec_t        v;

      vecs[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 2, 32'h1111_2222, 0,
                  32'h0, 1'b0, 3};
      vecs[1] = '{1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 32'h1234_5678, 0,
                  32'h1234_5678, 1'b0, 1};
      vecs[2] = '{1'b0, 32'h3000_0008, 32'h0, 4'h3, 100, 32'h5555_AAAA, 1,
                  ERR_DAT, 1'b1, 8};
      vecs[3] = '{1'b0, 32'h3000_000C, 32'h0, 4'hC, 7, 32'hCAFE_F00D, 0,
                  32'hCAFE_F00D, 1'b0, 8};
      vecs[4] = '{1'b1, 32'h4000_0010, 32'h0BAD_C0DE, 4'h1, 1, 32'h7777_7777, 5,
                  32'h0, 1'b0, 2};
      vecs[5] = '{1'b1, 32'h4000_0014, 32'h1357_9BDF, 4'h8, 100, 32'h0, 2,
                  ERR_DAT, 1'b1, 8};

      ifc.cmd_valid = 1'b0;
      ifc.cmd_we    = 1'b0;
      ifc.cmd_adr   = '0;
      ifc.cmd_dat   = '0;
      ifc.cmd_sel   = '0;
      ifc.rsp_ready = 1'b0;
      ifc.wbm_dat_i = '0;
      ifc.wbm_ack_i = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      chk("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
      chk("rst_busy", 32'(ifc.busy), 32'd0);
      chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      chk("rst_rsp_dat", ifc.rsp_dat, 32'd0);
      chk("rst_rsp_err", 32'(ifc.rsp_err), 32'd0);
      chk("rst_cyc", 32'(ifc.wbm_cyc_o), 32'd0);
      chk("rst_stb", 32'(ifc.wbm_stb_o), 32'd0);
      chk("rst_adr", ifc.wbm_adr_o, 32'd0);
      chk("rst_sel", 32'(ifc.wbm_sel_o), 32'd0);

      // Ack while idle must not disturb anything.
      ifc.wbm_ack_i = 1'b1;
      repeat (2) begin
         tick();
         chk("idle_ack_busy", 32'(ifc.busy), 32'd0);
         chk("idle_ack_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      end
      ifc.wbm_ack_i = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_cmd(vecs[i], g_dat, g_err, len);
         $display("vec %0d: we=%0b adr=%h rsp_dat=%h rsp_err=%0b cyc_len=%0d",
                  i, vecs[i].we, vecs[i].adr, g_dat, g_err, len);
         chk("vec_rsp_dat", g_dat, vecs[i].exp_dat);
         chk("vec_rsp_err", 32'(g_err), 32'(vecs[i].exp_err));
         chk("vec_cyc_len", len, vecs[i].exp_len);
      end

      // Reset in the third BUS cycle aborts the command without a response.
      ifc.cmd_valid = 1'b1;
      ifc.cmd_we    = 1'b0;
      ifc.cmd_adr   = 32'h5000_0000;
      ifc.cmd_sel   = 4'hF;
      tick();
      ifc.cmd_valid = 1'b0;
      chk("abort_cyc1", 32'(ifc.wbm_cyc_o), 32'd1);
      repeat (2) tick();
      chk("abort_cyc3", 32'(ifc.wbm_cyc_o), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_cyc", 32'(ifc.wbm_cyc_o), 32'd0);
      chk("abort_stb", 32'(ifc.wbm_stb_o), 32'd0);
      chk("abort_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
      chk("abort_busy", 32'(ifc.busy), 32'd0);
      repeat (4) begin
         ifc.wbm_ack_i = 1'b1;
         tick();
         chk("abort_no_rsp", 32'(ifc.rsp_valid), 32'd0);
      end
      ifc.wbm_ack_i = 1'b0;
      $display("reset abort: cyc=%0b rsp_valid=%0b cmd_ready=%0b",
               ifc.wbm_cyc_o, ifc.rsp_valid, ifc.cmd_ready);

      for (int i = 0; i < 40; i++) begin
         v.we        = 1'($urandom_range(0, 1));
         v.adr       = $urandom;
         v.dat       = $urandom;
         v.sel       = 4'($urandom_range(0, 15));
         v.ack_delay = int'($urandom_range(0, 11));
         v.sdata     = $urandom;
         v.rsp_wait  = int'($urandom_range(0, 3));
         v = model(v);
         run_cmd(v, g_dat, g_err, len);
         $display("rand %0d: we=%0b ack_delay=%0d rsp_dat=%h rsp_err=%0b cyc_len=%0d",
                  i, v.we, v.ack_delay, g_dat, g_err, len);
         chk("rand_rsp_dat", g_dat, v.exp_dat);
         chk("rand_rsp_err", 32'(g_err), 32'(v.exp_err));
         chk("rand_cyc_len", len, v.exp_len);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
